// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared widths and writeback request types for the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module      : wb_scoreboard
// Description : Per-register pending bits for long-latency destinations,
//               issue acceptance and RAW hazard detection for decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_scoreboard
    import core_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    output logic          hz_stall
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            set_en;

    assign iss_ready = ~pending_q[iss_rd] | (iss_rd == '0);
    assign set_en    = iss_valid & iss_ready & (iss_rd != '0);

    assign hz_stall = ((rs1_addr != '0) & pending_q[rs1_addr]) |
                      ((rs2_addr != '0) & pending_q[rs2_addr]);

    // Clear is applied before set so a same-edge reissue keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write port owner; arbitrates ALU/LSU/MDU
//               writeback and tracks long-latency pending destinations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [AW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            hz_stall,
    output logic            rd_wren,
    output logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);

    wb_req_t alu_req;
    wb_req_t lsu_req;
    wb_req_t mdu_req;
    wb_req_t sel_req;
    wb_src_e sel_src;

    logic            rr_q;
    logic            rr_d;
    logic            wren_q;
    logic            wren_d;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    wb_src_e         src_q;
    wb_src_e         src_d;
    logic            long_wr;

    assign alu_req = {alu_valid, alu_rd, alu_data};
    assign lsu_req = {lsu_valid, lsu_rd, lsu_data};
    assign mdu_req = {mdu_valid, mdu_rd, mdu_data};

    // rr_q = 0 favours LSU on a tie, 1 favours MDU.
    always_comb begin
        sel_req   = '0;
        sel_src   = WB_ALU;
        rr_d      = rr_q;
        lsu_ready = 1'b0;
        mdu_ready = 1'b0;
        alu_ready = ~lsu_valid & ~mdu_valid;
        if (lsu_req.valid && mdu_req.valid) begin
            if (!rr_q) begin
                sel_req   = lsu_req;
                sel_src   = WB_LSU;
                lsu_ready = 1'b1;
            end else begin
                sel_req   = mdu_req;
                sel_src   = WB_MDU;
                mdu_ready = 1'b1;
            end
            rr_d = ~rr_q;
        end else if (lsu_req.valid) begin
            sel_req   = lsu_req;
            sel_src   = WB_LSU;
            lsu_ready = 1'b1;
            rr_d      = 1'b1;
        end else if (mdu_req.valid) begin
            sel_req   = mdu_req;
            sel_src   = WB_MDU;
            mdu_ready = 1'b1;
            rr_d      = 1'b0;
        end else if (alu_req.valid) begin
            sel_req   = alu_req;
            sel_src   = WB_ALU;
        end
    end

    // Writes to x0 are accepted upstream but never reach the register file.
    always_comb begin
        wren_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        src_d  = src_q;
        if (sel_req.valid && (sel_req.rd != '0)) begin
            wren_d = 1'b1;
            addr_d = sel_req.rd;
            data_d = sel_req.data;
            src_d  = sel_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= 1'b0;
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= WB_ALU;
        end else begin
            rr_q   <= rr_d;
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
            src_q  <= src_d;
        end
    end

    assign rd_wren = wren_q;
    assign rd_addr = addr_q;
    assign rd_data = data_q;
    assign long_wr = wren_q & (src_q != WB_ALU);

    wb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .clr_en    (long_wr),
        .clr_addr  (addr_q),
        .hz_stall  (hz_stall)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, mdu_valid, iss_valid;
    logic        alu_ready, lsu_ready, mdu_ready, iss_ready;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd, iss_rd, rs1_addr, rs2_addr;
    logic [31:0] alu_data, lsu_data, mdu_data;
    logic        hz_stall, rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sh_pend = '0;

    always #5 clk = ~clk;

    wb_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .hz_stall  (hz_stall),
        .rd_wren   (rd_wren),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Decode must never let an ALU result target a register awaiting a long op.
    always @(posedge clk) begin
        if (!rst && alu_valid && alu_ready && alu_rd != 5'd0)
            assert (!sh_pend[alu_rd]) else $error("ALU write to pending x%0d", alu_rd);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; lsu_valid = 0; mdu_valid = 0; iss_valid = 0;
        alu_rd = 0; lsu_rd = 0; mdu_rd = 0; iss_rd = 0;
        alu_data = 0; lsu_data = 0; mdu_data = 0;
        rs1_addr = 0; rs2_addr = 0;
        step();
        step();
        chk("rst_wren", {31'd0, rd_wren}, 32'd0);
        chk("rst_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        rst = 1'b0;
        step();

        // ALU single write
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        #1 chk("alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 0; rs1_addr = 5'd5;
        #1;
        chk("alu_wren", {31'd0, rd_wren}, 32'd1);
        chk("alu_addr", {27'd0, rd_addr}, 32'd5);
        chk("alu_data", rd_data, 32'h0000_00AA);
        chk("alu_no_pend", {31'd0, hz_stall}, 32'd0);
        rs1_addr = 0;

        // LSU/MDU tie with ALU waiting: LSU, then MDU, then ALU
        lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h11;
        mdu_valid = 1; mdu_rd = 5'd4; mdu_data = 32'h22;
        alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h33;
        #1;
        chk("tie_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("tie_mdu_ready", {31'd0, mdu_ready}, 32'd0);
        chk("tie_alu_ready1", {31'd0, alu_ready}, 32'd0);
        step();
        lsu_valid = 0;
        #1;
        chk("tie_wr1_addr", {27'd0, rd_addr}, 32'd3);
        chk("tie_wr1_data", rd_data, 32'h11);
        chk("tie_mdu_ready2", {31'd0, mdu_ready}, 32'd1);
        chk("tie_alu_ready2", {31'd0, alu_ready}, 32'd0);
        step();
        mdu_valid = 0;
        #1;
        chk("tie_wr2_addr", {27'd0, rd_addr}, 32'd4);
        chk("tie_wr2_data", rd_data, 32'h22);
        chk("tie_alu_ready3", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 0;
        #1;
        chk("tie_wr3_addr", {27'd0, rd_addr}, 32'd6);
        chk("tie_wr3_data", rd_data, 32'h33);

        // Load to x7 with RAW hazard on rs1
        iss_valid = 1; iss_rd = 5'd7;
        #1 chk("ld_iss_ready", {31'd0, iss_ready}, 32'd1);
        step();
        iss_valid = 0; sh_pend[7] = 1; rs1_addr = 5'd7;
        #1 chk("ld_hz_pend", {31'd0, hz_stall}, 32'd1);
        lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'hDEAD_BEEF;
        #1 chk("ld_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        lsu_valid = 0;
        #1;
        chk("ld_wren", {31'd0, rd_wren}, 32'd1);
        chk("ld_addr", {27'd0, rd_addr}, 32'd7);
        chk("ld_data", rd_data, 32'hDEAD_BEEF);
        chk("ld_hz_wr_cycle", {31'd0, hz_stall}, 32'd1);
        step();
        sh_pend[7] = 0;
        chk("ld_hz_after", {31'd0, hz_stall}, 32'd0);
        chk("ld_wren_idle", {31'd0, rd_wren}, 32'd0);
        chk("ld_addr_hold", {27'd0, rd_addr}, 32'd7);
        rs1_addr = 0;

        // Reissue to pending x9 blocked until its writeback commits
        iss_valid = 1; iss_rd = 5'd9;
        step();
        sh_pend[9] = 1;
        chk("dup_iss_blocked", {31'd0, iss_ready}, 32'd0);
        iss_valid = 0; rs2_addr = 5'd9;
        lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        lsu_valid = 0;
        #1;
        chk("dup_wr_cycle_ready", {31'd0, iss_ready}, 32'd0);
        chk("dup_hz_rs2", {31'd0, hz_stall}, 32'd1);
        step();
        sh_pend[9] = 0;
        chk("dup_iss_free", {31'd0, iss_ready}, 32'd1);
        rs2_addr = 0;

        // Issue on the same edge that clears x10: set must win
        lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 32'h10;
        step();
        lsu_valid = 0; iss_valid = 1; iss_rd = 5'd10;
        #1;
        chk("sw_wren", {31'd0, rd_wren}, 32'd1);
        chk("sw_iss_ready", {31'd0, iss_ready}, 32'd1);
        step();
        iss_valid = 0; sh_pend[10] = 1; rs1_addr = 5'd10;
        #1 chk("sw_set_wins", {31'd0, hz_stall}, 32'd1);
        lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 32'h1010;
        step();
        lsu_valid = 0;
        step();
        sh_pend[10] = 0;
        chk("sw_cleared", {31'd0, hz_stall}, 32'd0);
        rs1_addr = 0;

        // MDU to x0: accepted, no write
        mdu_valid = 1; mdu_rd = 5'd0; mdu_data = 32'hFFFF_FFFF;
        #1 chk("x0_mdu_ready", {31'd0, mdu_ready}, 32'd1);
        step();
        mdu_valid = 0;
        #1;
        chk("x0_wren", {31'd0, rd_wren}, 32'd0);
        chk("x0_data_hold", rd_data, 32'h1010);

        // Async reset during a pending writeback
        iss_valid = 1; iss_rd = 5'd12;
        step();
        iss_valid = 0; sh_pend[12] = 1;
        lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'hC;
        step();
        lsu_valid = 0; rs1_addr = 5'd12;
        #1;
        chk("ar_pre_wren", {31'd0, rd_wren}, 32'd1);
        chk("ar_pre_hz", {31'd0, hz_stall}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_wren", {31'd0, rd_wren}, 32'd0);
        chk("ar_hz", {31'd0, hz_stall}, 32'd0);
        chk("ar_addr", {27'd0, rd_addr}, 32'd0);
        sh_pend = '0;
        step();
        rst = 1'b0;
        iss_valid = 1; iss_rd = 5'd12;
        #1 chk("ar_iss_ready", {31'd0, iss_ready}, 32'd1);
        step();
        iss_valid = 0; rs1_addr = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
